// File: rtl/cmp_sequencer.sv
// Multi-cycle unsigned magnitude compare, 2 bits per cycle, MSB pair first, through a shared 2-bit slice.
// Latency: done pulses N = WIDTH/2 cycles after start is accepted (EARLY_EXIT=1: after the first unequal pair).
// Backpressure: none; start is ignored while busy, and accepted in IDLE or in the DONE cycle (back-to-back).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, a, b         request and operands, captured on the accepting edge
//   busy                high while pairs are being compared
//   done                one-cycle pulse when the result flags become valid
//   a_gt_b/eq/lt        registered one-hot result, held until the next accepted start

module cmp_slice2 (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic       o_gt,
    output logic       o_eq,
    output logic       o_lt
);
    assign o_gt = (i_a > i_b);
    assign o_eq = (i_a == i_b);
    assign o_lt = (i_a < i_b);
endmodule

module cmp_sequencer #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
    localparam bit EE = (EARLY_EXIT != 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CW-1:0]    r_cnt;
    logic             r_diff;   // an unequal pair has already been seen
    logic             r_gt;     // direction of that first difference

    logic w_gt;
    logic w_eq;
    logic w_lt;

    cmp_slice2 u_slice (
        .i_a  (r_sa[WIDTH-1 -: 2]),
        .i_b  (r_sb[WIDTH-1 -: 2]),
        .o_gt (w_gt),
        .o_eq (w_eq),
        .o_lt (w_lt)
    );

    // The pair evaluated on the final edge must be folded into the result,
    // but only if no earlier (more significant) pair already decided it.
    logic w_first_ne;
    logic w_last;
    logic w_diff_fin;
    logic w_gt_fin;
    logic w_lt_fin;

    assign w_first_ne = !r_diff && !w_eq;
    assign w_last     = (r_cnt == '0) || (EE && w_first_ne);
    assign w_diff_fin = r_diff || !w_eq;
    assign w_gt_fin   = r_diff ? r_gt  : w_gt;
    assign w_lt_fin   = r_diff ? !r_gt : w_lt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_diff  <= 1'b0;
            r_gt    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_gt_b  <= 1'b0;
            a_eq_b  <= 1'b0;
            a_lt_b  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_cnt   <= CNT_INIT;
                        r_diff  <= 1'b0;
                        r_gt    <= 1'b0;
                        a_gt_b  <= 1'b0;
                        a_eq_b  <= 1'b0;
                        a_lt_b  <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_COMPARE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_COMPARE: begin
                    if (w_first_ne) begin
                        r_diff <= 1'b1;
                        r_gt   <= w_gt;
                    end
                    r_sa <= r_sa << 2;
                    r_sb <= r_sb << 2;
                    if (w_last) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        a_gt_b  <= w_diff_fin && w_gt_fin;
                        a_lt_b  <= w_diff_fin && w_lt_fin;
                        a_eq_b  <= !w_diff_fin;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_sequencer.sv
// Bench for cmp_sequencer: instance 0 has EARLY_EXIT=0, instance 1 has EARLY_EXIT=1.
// Expected results (flags + completion cycle) are queued at issue time and checked by a monitor on done.
// Directed checks cover reset values, busy window, flag clearing, flag hold and asynchronous abort.
`timescale 1ns/1ps
module tb_cmp_sequencer;
    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_s [2];
    logic [7:0] a_s     [2];
    logic [7:0] b_s     [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       gt_s    [2];
    logic       eq_s    [2];
    logic       lt_s    [2];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmp_sequencer #(.WIDTH(8), .EARLY_EXIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .a_gt_b(gt_s[0]), .a_eq_b(eq_s[0]), .a_lt_b(lt_s[0])
    );
    cmp_sequencer #(.WIDTH(8), .EARLY_EXIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .a_gt_b(gt_s[1]), .a_eq_b(eq_s[1]), .a_lt_b(lt_s[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon_check(input int k, input exp_t e);
        chk($sformatf("dut%0d done cycle", k), cyc, e.cyc);
        chk($sformatf("dut%0d a_gt_b", k), int'(gt_s[k]), int'(e.gt));
        chk($sformatf("dut%0d a_eq_b", k), int'(eq_s[k]), int'(e.eq));
        chk($sformatf("dut%0d a_lt_b", k), int'(lt_s[k]), int'(e.lt));
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done_s[0] === 1'b1) begin
            if (q0.size() == 0) chk("dut0 unexpected done", 1, 0);
            else mon_check(0, q0.pop_front());
        end
        if (done_s[1] === 1'b1) begin
            if (q1.size() == 0) chk("dut1 unexpected done", 1, 0);
            else mon_check(1, q1.pop_front());
        end
    end

    // Called at a negedge; start is sampled at the next posedge (E0) and
    // done is expected to be observed lat cycles after E0.
    task automatic issue(input int k, input logic [7:0] av, input logic [7:0] bv,
                         input logic egt, input logic eeq, input logic elt,
                         input int lat, input bit push);
        exp_t e;
        e.gt  = egt;
        e.eq  = eeq;
        e.lt  = elt;
        e.cyc = cyc + 1 + lat;
        if (push) begin
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        start_s[k] = 1'b1;
        a_s[k] = av;
        b_s[k] = bv;
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    // Returns at the negedge where done is high (the DONE cycle).
    task automatic wait_done(input int k);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_s[k] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk($sformatf("dut%0d done timeout", k), 0, 1);
    endtask

    task automatic chk_all_zero(input int k, input string tag);
        chk($sformatf("%s dut%0d busy", tag, k), int'(busy_s[k]), 0);
        chk($sformatf("%s dut%0d done", tag, k), int'(done_s[k]), 0);
        chk($sformatf("%s dut%0d gt", tag, k), int'(gt_s[k]), 0);
        chk($sformatf("%s dut%0d eq", tag, k), int'(eq_s[k]), 0);
        chk($sformatf("%s dut%0d lt", tag, k), int'(lt_s[k]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0;
            a_s[k] = '0;
            b_s[k] = '0;
        end
        #12;
        chk_all_zero(0, "reset");
        chk_all_zero(1, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- EARLY_EXIT = 0 ----------------
        // Equal operands: busy after E0..E3, low with done after E4.
        issue(0, 8'hA5, 8'hA5, 0, 1, 0, 4, 1);
        for (int i = 0; i < 4; i++) begin
            chk("eq busy window", int'(busy_s[0]), 1);
            @(negedge clk);
        end
        chk("eq busy after E4", int'(busy_s[0]), 0);
        wait_done(0);
        @(negedge clk);
        chk("done one cycle", int'(done_s[0]), 0);

        // MSB pair decides; lower pairs (00<11) must not override.
        issue(0, 8'h80, 8'h7F, 1, 0, 0, 4, 1);
        wait_done(0);
        // Back-to-back: start held during the DONE cycle.
        issue(0, 8'hF0, 8'h0F, 1, 0, 0, 4, 1);
        chk("b2b busy", int'(busy_s[0]), 1);
        chk("b2b gt cleared", int'(gt_s[0]), 0);
        chk("b2b eq cleared", int'(eq_s[0]), 0);
        chk("b2b lt cleared", int'(lt_s[0]), 0);
        wait_done(0);
        @(negedge clk);

        // Start and operand changes while busy are ignored.
        issue(0, 8'h01, 8'h02, 0, 0, 1, 4, 1);
        @(negedge clk);
        start_s[0] = 1'b1;
        a_s[0] = 8'hFF;
        b_s[0] = 8'h00;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_done(0);
        // Result hold in IDLE.
        repeat (3) @(negedge clk);
        chk("hold lt", int'(lt_s[0]), 1);
        chk("hold gt", int'(gt_s[0]), 0);
        chk("hold eq", int'(eq_s[0]), 0);
        chk("hold no done", int'(done_s[0]), 0);

        // Asynchronous abort between E2 and E3; no done for this request.
        issue(0, 8'h12, 8'h34, 0, 0, 1, 4, 0);
        @(negedge clk);
        @(negedge clk);
        chk("pre-abort busy", int'(busy_s[0]), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero(0, "abort");
        repeat (3) @(negedge clk);
        chk("abort no done", int'(done_s[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 8'h12, 8'h13, 0, 0, 1, 4, 1);
        wait_done(0);
        @(negedge clk);

        // ---------------- EARLY_EXIT = 1 ----------------
        issue(1, 8'h80, 8'h7F, 1, 0, 0, 1, 1);   // pair 1 decides
        wait_done(1);
        @(negedge clk);
        issue(1, 8'h12, 8'h13, 0, 0, 1, 4, 1);   // only last pair differs
        wait_done(1);
        @(negedge clk);
        issue(1, 8'h33, 8'h33, 0, 1, 0, 4, 1);   // equal: full length
        wait_done(1);
        @(negedge clk);
        issue(1, 8'h40, 8'h80, 0, 0, 1, 1, 1);   // 01 < 10 in pair 1
        wait_done(1);
        @(negedge clk);
        issue(1, 8'h9C, 8'h98, 1, 0, 0, 3, 1);   // 11 > 10 in pair 3
        wait_done(1);
        issue(1, 8'h05, 8'h06, 0, 0, 1, 4, 1);   // back-to-back, 01 < 10 in pair 4
        wait_done(1);
        @(negedge clk);
        repeat (3) @(negedge clk);

        chk("dut0 queue drained", q0.size(), 0);
        chk("dut1 queue drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
